// File: rtl/seq_det_1101_if.sv
// Bundle of sample, clear and status signals for the 1101 serial pattern detector.
// The testbench side uses the master modport and the detector uses the slave modport.
interface seq_det_1101_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             d;
    logic             clr;
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       state;

    modport master (
        output en,
        output d,
        output clr,
        input  match,
        input  cnt,
        input  state
    );

    modport slave (
        input  en,
        input  d,
        input  clr,
        output match,
        output cnt,
        output state
    );
endinterface

// File: rtl/seq_det_1101.sv
// Moore detector for the serial pattern 1101 with a saturating detection counter.
// Define SEQ_DET_OVERLAP_EN so that a match's trailing '1' can start the next pattern.
module seq_det_1101 #(
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_det_1101_if.slave   bus
);
    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S11   = 3'd2,
        S110  = 3'd3,
        S1101 = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             match_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             enter_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Next-state decode; codes 5-7 fall back to S0 on the next enabled edge.
    always_comb begin
        state_next_s = state_r;
        enter_s      = 1'b0;
        if (bus.en) begin
            case (state_r)
                S0: begin
                    if (bus.d) state_next_s = S1;
                    else       state_next_s = S0;
                end
                S1: begin
                    if (bus.d) state_next_s = S11;
                    else       state_next_s = S0;
                end
                S11: begin
                    if (bus.d) state_next_s = S11;
                    else       state_next_s = S110;
                end
                S110: begin
                    if (bus.d) begin
                        state_next_s = S1101;
                        enter_s      = 1'b1;
                    end else begin
                        state_next_s = S0;
                    end
                end
                S1101: begin
`ifdef SEQ_DET_OVERLAP_EN
                    if (bus.d) state_next_s = S11;
                    else       state_next_s = S0;
`else
                    if (bus.d) state_next_s = S1;
                    else       state_next_s = S0;
`endif
                end
                default: begin
                    state_next_s = S0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Counter update: clear wins over the increment on entry to S1101.
    always_comb begin
        cnt_next_s = cnt_r;
        if (bus.clr) begin
            cnt_next_s = '0;
        end else if (enter_s) begin
            cnt_next_s = sat_inc(cnt_r);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State, match flag and counter registers; match is decoded from next state so it stays registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S0;
            match_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            match_r <= (state_next_s == S1101);
            cnt_r   <= cnt_next_s;
        end
    end

    assign bus.state = state_r;
    assign bus.match = match_r;
    assign bus.cnt   = cnt_r;
endmodule

// File: tb/tb_seq_det_1101.sv
// Directed self-checking bench for seq_det_1101: a default-width and a 2-bit-counter instance share stimulus.
// Expectations for the overlap scenario follow whether SEQ_DET_OVERLAP_EN is defined.
module tb_seq_det_1101;
    logic clk;
    logic rst_n;
    logic en;
    logic d;
    logic clr;
    int   total;
    int   bad;

    seq_det_1101_if #(.CNT_W(8)) bus8 ();
    seq_det_1101_if #(.CNT_W(2)) bus2 ();

    assign bus8.en  = en;
    assign bus8.d   = d;
    assign bus8.clr = clr;
    assign bus2.en  = en;
    assign bus2.d   = d;
    assign bus2.clr = clr;

    seq_det_1101 #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    seq_det_1101 #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic e, input logic dv, input logic c);
        @(negedge clk);
        en  = e;
        d   = dv;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        en    = 1'b0;
        d     = 1'b0;
        clr   = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #7;
        total++;
        if (bus8.state !== 3'd0 || bus8.match !== 1'b0 || bus8.cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_init state=%0d match=%0d cnt=%0d want 0 0 0", bus8.state, bus8.match, bus8.cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (bus8.state !== 3'd3) begin
            bad++;
            $display("FAIL reset_prefix state=%0d want 3", bus8.state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus8.state !== 3'd0 || bus8.match !== 1'b0 || bus8.cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_async state=%0d match=%0d cnt=%0d want 0 0 0", bus8.state, bus8.match, bus8.cnt);
        end
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (bus8.state !== 3'd1 || bus8.match !== 1'b0) begin
            bad++;
            $display("FAIL reset_resume state=%0d match=%0d want 1 0", bus8.state, bus8.match);
        end
    endtask

    task automatic test_overlap();
        logic       bits [7];
        logic [2:0] exp_st [7];
        logic [7:0] exp_cnt;
        bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
`ifdef SEQ_DET_OVERLAP_EN
        exp_st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
        exp_cnt = 8'd2;
`else
        exp_st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd0, 3'd1};
        exp_cnt = 8'd1;
`endif
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[i], 1'b0);
            total++;
            if (bus8.state !== exp_st[i] || bus8.match !== (exp_st[i] == 3'd4)) begin
                bad++;
                $display("FAIL overlap_bit%0d state=%0d match=%0d want %0d %0d", i + 1, bus8.state, bus8.match, exp_st[i], (exp_st[i] == 3'd4));
            end
        end
        total++;
        if (bus8.cnt !== exp_cnt) begin
            bad++;
            $display("FAIL overlap_cnt cnt=%0d want %0d", bus8.cnt, exp_cnt);
        end
    endtask

    task automatic test_prefix_loop();
        logic       bits [5];
        logic [2:0] exp_st [5];
        bits   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_st = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd4};
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bits[i], 1'b0);
            total++;
            if (bus8.state !== exp_st[i] || bus8.match !== (i == 4)) begin
                bad++;
                $display("FAIL prefix_bit%0d state=%0d match=%0d want %0d %0d", i + 1, bus8.state, bus8.match, exp_st[i], (i == 4));
            end
        end
        total++;
        if (bus8.cnt !== 8'd1) begin
            bad++;
            $display("FAIL prefix_cnt cnt=%0d want 1", bus8.cnt);
        end
    endtask

    task automatic test_en_gating();
        pulse_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (bus8.state !== 3'd2 || bus8.match !== 1'b0) begin
                bad++;
                $display("FAIL gate_hold%0d state=%0d match=%0d want 2 0", i, bus8.state, bus8.match);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (bus8.state !== 3'd4 || bus8.match !== 1'b1 || bus8.cnt !== 8'd1) begin
            bad++;
            $display("FAIL gate_match state=%0d match=%0d cnt=%0d want 4 1 1", bus8.state, bus8.match, bus8.cnt);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0);
            total++;
            if (bus8.state !== 3'd4 || bus8.match !== 1'b1 || bus8.cnt !== 8'd1) begin
                bad++;
                $display("FAIL gate_match_hold%0d state=%0d match=%0d cnt=%0d want 4 1 1", i, bus8.state, bus8.match, bus8.cnt);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (bus8.state !== 3'd0 || bus8.match !== 1'b0 || bus8.cnt !== 8'd1) begin
            bad++;
            $display("FAIL gate_release state=%0d match=%0d cnt=%0d want 0 0 1", bus8.state, bus8.match, bus8.cnt);
        end
    endtask

    task automatic test_sat_clear();
        logic [1:0] exp_c2 [4];
        exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3};
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            total++;
            if (bus2.cnt !== exp_c2[k] || bus2.match !== 1'b1) begin
                bad++;
                $display("FAIL sat_det%0d cnt=%0d match=%0d want %0d 1", k + 1, bus2.cnt, bus2.match, exp_c2[k]);
            end
            step(1'b1, 1'b0, 1'b0);
        end
        total++;
        if (bus8.cnt !== 8'd4) begin
            bad++;
            $display("FAIL sat_wide_cnt cnt=%0d want 4", bus8.cnt);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        total++;
        if (bus2.cnt !== 2'd0 || bus2.match !== 1'b1 || bus2.state !== 3'd4 || bus8.cnt !== 8'd0) begin
            bad++;
            $display("FAIL clr_priority cnt2=%0d match=%0d state=%0d cnt8=%0d want 0 1 4 0", bus2.cnt, bus2.match, bus2.state, bus8.cnt);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        total++;
        if (bus2.cnt !== 2'd1 || bus8.cnt !== 8'd1) begin
            bad++;
            $display("FAIL post_clr_cnt cnt2=%0d cnt8=%0d want 1 1", bus2.cnt, bus8.cnt);
        end
        step(1'b0, 1'b0, 1'b1);
        total++;
        if (bus8.cnt !== 8'd0 || bus8.state !== 3'd4 || bus8.match !== 1'b1) begin
            bad++;
            $display("FAIL clr_no_en cnt=%0d state=%0d match=%0d want 0 4 1", bus8.cnt, bus8.state, bus8.match);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        d     = 1'b0;
        clr   = 1'b0;
        test_reset();
        test_overlap();
        test_prefix_loop();
        test_en_gating();
        test_sat_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
